// File: rtl/tgif_bus_pkg.sv
// Shared constants and elaboration-time helpers for the TGIF bus adapter.
package tgif_bus_pkg;

    localparam int unsigned CORE_WIDTH = 32;

    // Narrow beats per 32-bit core word.
    function automatic int unsigned ratio(input int unsigned bus_width);
        return CORE_WIDTH / bus_width;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tgif_upsizer.sv
// Packs BUSWIDTH-bit beats big-endian into 32-bit core words with valid/ready on both sides.
module tgif_upsizer
    import tgif_bus_pkg::*;
#(
    parameter int unsigned BUSWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [BUSWIDTH-1:0]   beat_data,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    output logic [CORE_WIDTH-1:0] word,
    output logic                  word_valid,
    input  logic                  word_ready
);

    localparam int unsigned R  = ratio(BUSWIDTH);
    localparam int unsigned CW = clog2(R + 1);

    logic [CW-1:0]         cnt;
    logic                  full;
    logic                  accept;
    logic                  take;
    logic [CORE_WIDTH-1:0] next_word;

    assign full       = (cnt == CW'(R));
    assign word_valid = full;
    assign beat_ready = rst & (~full | word_ready);
    assign accept     = beat_valid & beat_ready;
    assign take       = full & word_ready;

    // Older beats shift toward the MSB so the first beat ends up in the top slice.
    if (BUSWIDTH == CORE_WIDTH) begin : g_pass
        assign next_word = beat_data;
    end else begin : g_shift
        assign next_word = {word[CORE_WIDTH-BUSWIDTH-1:0], beat_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= full ? CW'(1) : cnt + CW'(1);
        end else if (take) begin
            cnt <= '0;
        end
    end

    // Data register is never cleared; cnt alone says whether it holds a word.
    always_ff @(posedge clk) begin
        if (rst && !flush && accept) begin
            word <= next_word;
        end
    end

endmodule

// File: rtl/tgif_bus_adapter.sv
// LWC bus front end for the TGIF core: PDI/SDI upsizers plus a buffered PDO downsizer.
// Optional macro TGIF_PDO_FIFO_EN selects a DEPTH-word PDO FIFO instead of one holding register.
module tgif_bus_adapter
    import tgif_bus_pkg::*;
#(
    parameter int unsigned BUSWIDTH = 32,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [BUSWIDTH-1:0]   pdi_data,
    input  logic                  pdi_valid,
    output logic                  pdi_ready,
    input  logic [BUSWIDTH-1:0]   sdi_data,
    input  logic                  sdi_valid,
    output logic                  sdi_ready,
    output logic [BUSWIDTH-1:0]   pdo_data,
    output logic                  pdo_valid,
    input  logic                  pdo_ready,
    output logic [CORE_WIDTH-1:0] core_pdi,
    output logic                  core_pdi_valid,
    input  logic                  core_pdi_ready,
    output logic [CORE_WIDTH-1:0] core_sdi,
    output logic                  core_sdi_valid,
    input  logic                  core_sdi_ready,
    input  logic [CORE_WIDTH-1:0] core_pdo,
    input  logic                  core_pdo_valid,
    output logic                  core_pdo_ready
);

    localparam int unsigned R   = ratio(BUSWIDTH);
    localparam int unsigned BIW = (R > 1) ? clog2(R) : 1;

    tgif_upsizer #(.BUSWIDTH(BUSWIDTH)) u_pdi (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .beat_data  (pdi_data),
        .beat_valid (pdi_valid),
        .beat_ready (pdi_ready),
        .word       (core_pdi),
        .word_valid (core_pdi_valid),
        .word_ready (core_pdi_ready)
    );

    tgif_upsizer #(.BUSWIDTH(BUSWIDTH)) u_sdi (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .beat_data  (sdi_data),
        .beat_valid (sdi_valid),
        .beat_ready (sdi_ready),
        .word       (core_sdi),
        .word_valid (core_sdi_valid),
        .word_ready (core_sdi_ready)
    );

    logic [BIW-1:0]        beat_idx;
    logic [CORE_WIDTH-1:0] pdo_head;
    logic [CORE_WIDTH-1:0] head_shift;
    logic [5:0]            shift_amt;
    logic                  pdo_beat;
    logic                  pop;
    logic                  push;

    assign pdo_beat = pdo_valid & pdo_ready;
    assign pop      = pdo_beat & (beat_idx == BIW'(R - 1));
    assign push     = core_pdo_valid & core_pdo_ready;

    // MSB-first serialisation: slide the current beat up to the top of the word.
    assign shift_amt  = 6'(beat_idx) * 6'(BUSWIDTH);
    assign head_shift = pdo_head << shift_amt;
    assign pdo_data   = head_shift[CORE_WIDTH-1 -: BUSWIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_idx <= '0;
        end else if (flush) begin
            beat_idx <= '0;
        end else if (pop) begin
            beat_idx <= '0;
        end else if (pdo_beat) begin
            beat_idx <= beat_idx + BIW'(1);
        end
    end

`ifdef TGIF_PDO_FIFO_EN
    localparam int unsigned PW = clog2(DEPTH);

    logic [CORE_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           occ;

    assign pdo_head       = mem[rd_ptr];
    assign pdo_valid      = (occ != '0);
    assign core_pdo_ready = rst & (occ != (PW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (PW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            mem[wr_ptr] <= core_pdo;
        end
    end
`else
    logic                  held;
    logic [CORE_WIDTH-1:0] hold_word;

    // DEPTH has no effect with the single holding register.
    if (DEPTH < 2) begin : g_depth_unused
    end

    assign pdo_head       = hold_word;
    assign pdo_valid      = held;
    assign core_pdo_ready = rst & ~held;

    always_ff @(posedge clk) begin
        if (!rst) begin
            held <= 1'b0;
        end else if (flush) begin
            held <= 1'b0;
        end else if (push) begin
            held <= 1'b1;
        end else if (pop) begin
            held <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            hold_word <= core_pdo;
        end
    end
`endif

endmodule

// File: tb/tb_tgif_bus_adapter.sv
// Randomized and directed bench for tgif_bus_adapter at an 8-bit external bus.
module tb_tgif_bus_adapter;

    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned R     = 32 / BW;
`ifdef TGIF_PDO_FIFO_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk;
    logic          rst;
    logic          flush;
    logic [BW-1:0] pdi_data;
    logic          pdi_valid;
    logic          pdi_ready;
    logic [BW-1:0] sdi_data;
    logic          sdi_valid;
    logic          sdi_ready;
    logic [BW-1:0] pdo_data;
    logic          pdo_valid;
    logic          pdo_ready;
    logic [31:0]   core_pdi;
    logic          core_pdi_valid;
    logic          core_pdi_ready;
    logic [31:0]   core_sdi;
    logic          core_sdi_valid;
    logic          core_sdi_ready;
    logic [31:0]   core_pdo;
    logic          core_pdo_valid;
    logic          core_pdo_ready;

    tgif_bus_adapter #(.BUSWIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .pdi_data       (pdi_data),
        .pdi_valid      (pdi_valid),
        .pdi_ready      (pdi_ready),
        .sdi_data       (sdi_data),
        .sdi_valid      (sdi_valid),
        .sdi_ready      (sdi_ready),
        .pdo_data       (pdo_data),
        .pdo_valid      (pdo_valid),
        .pdo_ready      (pdo_ready),
        .core_pdi       (core_pdi),
        .core_pdi_valid (core_pdi_valid),
        .core_pdi_ready (core_pdi_ready),
        .core_sdi       (core_sdi),
        .core_sdi_valid (core_sdi_valid),
        .core_sdi_ready (core_sdi_ready),
        .core_pdo       (core_pdo),
        .core_pdo_valid (core_pdo_valid),
        .core_pdo_ready (core_pdo_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: beats waiting to form a word, words waiting to leave, beat position in head word.
    logic [BW-1:0] pq[$];
    logic [BW-1:0] sq[$];
    logic [31:0]   fq[$];
    int unsigned   bidx = 0;

    // Observed outputs of the last cycle, for directed spot checks.
    logic          o_pdi_ready;
    logic          o_sdi_ready;
    logic          o_cpv;
    logic [31:0]   o_cp;
    logic          o_cpo_ready;
    logic          o_pdo_valid;
    logic [BW-1:0] o_pdo_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [BW-1:0] q[$]);
        logic [31:0] w;
        w = '0;
        foreach (q[i]) w = (w << BW) | 32'(q[i]);
        return w;
    endfunction

    function automatic logic [BW-1:0] beat_of(input logic [31:0] w, input int unsigned k);
        return BW'(w >> (32 - BW * (k + 1)));
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model over the posedge.
    task automatic cycle(input bit rst_on, input bit fl,
                         input bit pv, input logic [BW-1:0] pd,
                         input bit sv, input logic [BW-1:0] sd,
                         input bit cpr, input bit csr,
                         input bit cpov, input logic [31:0] cpo, input bit por);
        bit e_pr;
        bit e_sr;
        bit e_cr;
        @(negedge clk);
        rst = ~rst_on; flush = fl;
        pdi_valid = pv; pdi_data = pd; sdi_valid = sv; sdi_data = sd;
        core_pdi_ready = cpr; core_sdi_ready = csr;
        core_pdo_valid = cpov; core_pdo = cpo; pdo_ready = por;
        #1;
        e_pr = !rst_on && (pq.size() < R || cpr);
        e_sr = !rst_on && (sq.size() < R || csr);
        e_cr = !rst_on && (fq.size() < CAP);
        check("pdi_ready", 32'(pdi_ready), 32'(e_pr));
        check("sdi_ready", 32'(sdi_ready), 32'(e_sr));
        check("core_pdo_ready", 32'(core_pdo_ready), 32'(e_cr));
        check("core_pdi_valid", 32'(core_pdi_valid), 32'(pq.size() == R));
        check("core_sdi_valid", 32'(core_sdi_valid), 32'(sq.size() == R));
        check("pdo_valid", 32'(pdo_valid), 32'(fq.size() != 0));
        if (pq.size() == R) check("core_pdi", core_pdi, pack(pq));
        if (sq.size() == R) check("core_sdi", core_sdi, pack(sq));
        if (fq.size() != 0) check("pdo_data", 32'(pdo_data), 32'(beat_of(fq[0], bidx)));
        o_pdi_ready = pdi_ready; o_sdi_ready = sdi_ready; o_cpv = core_pdi_valid;
        o_cp = core_pdi; o_cpo_ready = core_pdo_ready;
        o_pdo_valid = pdo_valid; o_pdo_data = pdo_data;
        if (rst_on || fl) begin
            pq.delete(); sq.delete(); fq.delete(); bidx = 0;
        end else begin
            if (pq.size() == R && cpr) pq.delete();
            if (pv && e_pr) pq.push_back(pd);
            if (sq.size() == R && csr) sq.delete();
            if (sv && e_sr) sq.push_back(sd);
            if (fq.size() != 0 && por) begin
                if (bidx == R - 1) begin
                    void'(fq.pop_front());
                    bidx = 0;
                end else begin
                    bidx++;
                end
            end
            if (cpov && e_cr) fq.push_back(cpo);
        end
    endtask

    task automatic idle(input bit cpr, input bit por);
        cycle(0, 0, 0, '0, 0, '0, cpr, 1, 0, '0, por);
    endtask

    initial begin
        logic [31:0] words [5];
        int          widx;
        rst = 1'b0; flush = 1'b0;
        pdi_valid = 1'b0; pdi_data = '0; sdi_valid = 1'b0; sdi_data = '0;
        core_pdi_ready = 1'b0; core_sdi_ready = 1'b0;
        core_pdo_valid = 1'b0; core_pdo = '0; pdo_ready = 1'b0;

        cycle(1, 0, 0, '0, 0, '0, 1, 1, 0, '0, 1);
        cycle(1, 0, 0, '0, 0, '0, 1, 1, 0, '0, 1);
        check("rst_pdi_ready", 32'(o_pdi_ready), 32'd0);
        check("rst_cpo_ready", 32'(o_cpo_ready), 32'd0);
        idle(1, 1);
        check("post_rst_pdi_ready", 32'(o_pdi_ready), 32'd1);
        check("post_rst_sdi_ready", 32'(o_sdi_ready), 32'd1);
        check("post_rst_cpo_ready", 32'(o_cpo_ready), 32'd1);

        // Back-to-back beats 01..04 into an always-ready core.
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 1, BW'(i), 1, BW'(8'h10 + i), 1, 1, 0, '0, 0);
            check("a_pdi_ready", 32'(o_pdi_ready), 32'd1);
        end
        idle(0, 0);
        check("a_core_pdi_valid", 32'(o_cpv), 32'd1);
        check("a_core_pdi", o_cp, 32'h01020304);
        idle(1, 0);

        // One word out, MSB-first, starting the cycle after the push.
        cycle(0, 0, 0, '0, 0, '0, 1, 1, 1, 32'hDEADBEEF, 1);
        check("b_no_bypass", 32'(o_pdo_valid), 32'd0);
        idle(1, 1);
        check("b_first_beat", 32'(o_pdo_data), 32'hDE);
        for (int i = 0; i < 3; i++) idle(1, 1);
        check("b_last_beat", 32'(o_pdo_data), 32'hEF);
        idle(1, 1);
        check("b_valid_drops", 32'(o_pdo_valid), 32'd0);

        // Five pushes against a stalled bus, then drain in order.
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        widx = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(0, 0, 0, '0, 0, '0, 1, 1, widx < 5, words[widx % 5], c >= 6);
            if (c == 5) check("c_full_ready", 32'(o_cpo_ready), 32'd0);
            if (o_cpo_ready && widx < 5) widx++;
        end
        check("c_all_pushed", 32'(widx), 32'd5);

        // Flush drops a partial word.
        cycle(0, 0, 1, 8'h91, 0, '0, 1, 1, 0, '0, 0);
        cycle(0, 0, 1, 8'h92, 0, '0, 1, 1, 0, '0, 0);
        cycle(0, 1, 1, 8'h93, 0, '0, 1, 1, 0, '0, 0);
        cycle(0, 0, 1, 8'hAA, 0, '0, 0, 1, 0, '0, 0);
        cycle(0, 0, 1, 8'hBB, 0, '0, 0, 1, 0, '0, 0);
        cycle(0, 0, 1, 8'hCC, 0, '0, 0, 1, 0, '0, 0);
        cycle(0, 0, 1, 8'hDD, 0, '0, 0, 1, 0, '0, 0);
        cycle(0, 0, 1, 8'h55, 0, '0, 0, 1, 0, '0, 0);
        check("d_flush_word", o_cp, 32'hAABBCCDD);
        check("d_stall_ready", 32'(o_pdi_ready), 32'd0);
        // Same-cycle take and accept.
        cycle(0, 0, 1, 8'h77, 0, '0, 1, 1, 0, '0, 0);
        check("e_take_accept", 32'(o_pdi_ready), 32'd1);
        cycle(0, 0, 0, '0, 0, '0, 1, 1, 0, '0, 0);
        cycle(0, 1, 0, '0, 0, '0, 1, 1, 0, '0, 0);

        // Reset in the middle of serialising a word.
        cycle(0, 0, 0, '0, 0, '0, 1, 1, 1, 32'h11223344, 1);
        idle(1, 1);
        idle(1, 1);
        cycle(1, 0, 1, 8'h01, 1, 8'h02, 1, 1, 1, 32'h5, 1);
        check("f_rst_pdi_ready", 32'(o_pdi_ready), 32'd0);
        check("f_rst_sdi_ready", 32'(o_sdi_ready), 32'd0);
        check("f_rst_cpo_ready", 32'(o_cpo_ready), 32'd0);
        idle(1, 1);
        check("f_pdo_empty", 32'(o_pdo_valid), 32'd0);
        idle(1, 1);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 4000; c++) begin
            int unsigned bias;
            bias = (c / 500) % 4;
            cycle($urandom_range(0, 599) == 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 3) != 0, BW'($urandom),
                  $urandom_range(0, 3) != 0, BW'($urandom),
                  $urandom_range(0, 3) >= bias, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 3) >= (3 - bias));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
